// File: rtl/sprite_line_drawer.sv
// Sprite FIFO drain engine: pops one descriptor per sprite, fetches its 16 ROM
// pixels and writes the opaque, on-screen ones into the scanline buffer.
module sprite_line_drawer #(
  parameter int X_W        = 10,
  parameter int ROW_W      = 4,
  parameter int ID_W       = 6,
  parameter int COL_W      = 4,
  parameter int PIX_W      = 8,
  parameter int LINE_WIDTH = 640
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic                        fifo_e,
  input  logic [X_W+ROW_W+ID_W-1:0]   fifo_data,
  output logic                        fifo_re,
  output logic [ID_W+ROW_W+COL_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]            rom_data,
  output logic                        lb_we,
  output logic [X_W-1:0]              lb_addr,
  output logic [PIX_W-1:0]            lb_data,
  output logic                        busy,
  output logic                        done
);

  localparam int BUS_WIDTH = X_W + ROW_W + ID_W;
  localparam logic [X_W:0] LINE_LIM = (X_W+1)'(LINE_WIDTH);

  typedef enum logic [1:0] {IDLE, LATCH, DRAW, FLUSH} state_t;

  state_t             state, next_state;
  logic               active;
  logic               done_r;
  logic               set_done;
  logic               clr_active;
  logic               start_acc;
  logic [X_W-1:0]     x_q;
  logic [ROW_W-1:0]   row_q;
  logic [ID_W-1:0]    id_q;
  logic [COL_W-1:0]   col_q;
  logic               vld_p1;
  logic [X_W:0]       x_p1;

  // Clip against the visible line; x_p1 carries one extra bit so x+col never wraps.
  function automatic logic on_line(input logic [X_W:0] px);
    return px < LINE_LIM;
  endfunction

  assign start_acc = start && (state == IDLE) && !active && !done_r;
  assign busy      = active | done_r;
  assign done      = done_r;
  assign rom_addr  = {id_q, row_q, col_q};

  always_comb begin
    next_state = state;
    fifo_re    = 1'b0;
    set_done   = 1'b0;
    clr_active = 1'b0;
    case (state)
      IDLE: begin
        if (active) begin
          if (!fifo_e) begin
            fifo_re    = 1'b1;
            next_state = LATCH;
          end else begin
            set_done   = 1'b1;
            clr_active = 1'b1;
          end
        end
      end
      LATCH: next_state = DRAW;
      DRAW: begin
        if (col_q == '1) next_state = FLUSH;
      end
      FLUSH: begin
        if (!fifo_e) begin
          fifo_re    = 1'b1;
          next_state = LATCH;
        end else begin
          next_state = IDLE;
          set_done   = 1'b1;
          clr_active = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      active <= 1'b0;
      done_r <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= next_state;
      done_r <= set_done;
      if (clr_active)     active <= 1'b0;
      else if (start_acc) active <= 1'b1;
      vld_p1 <= (state == DRAW);
    end
  end

  // Descriptor/column registers are reset so rom_addr and lb_addr come up at zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q   <= '0;
      row_q <= '0;
      id_q  <= '0;
      col_q <= '0;
      x_p1  <= '0;
    end else begin
      if (state == LATCH) begin
        x_q   <= fifo_data[BUS_WIDTH-1 -: X_W];
        row_q <= fifo_data[ID_W+ROW_W-1 -: ROW_W];
        id_q  <= fifo_data[ID_W-1:0];
        col_q <= '0;
      end else if (state == DRAW) begin
        col_q <= col_q + 1'b1;
      end
      // Stage p0 -> p1: ROM address issued now, pixel returns alongside x_p1.
      x_p1 <= {1'b0, x_q} + {{(X_W+1-COL_W){1'b0}}, col_q};
    end
  end

  assign lb_we   = vld_p1 && (rom_data != '0) && on_line(x_p1);
  assign lb_addr = x_p1[X_W-1:0];
  assign lb_data = rom_data;

endmodule

// File: tb/tb_sprite_line_drawer.sv
// Scoreboard bench for sprite_line_drawer with behavioural FIFO and sprite ROM.
module tb_sprite_line_drawer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        fifo_e;
  logic [19:0] fifo_data = '0;
  logic        fifo_re;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_data;
  logic        busy;
  logic        done;

  sprite_line_drawer dut (
    .Clk(Clk), .Reset(Reset), .start(start), .fifo_e(fifo_e),
    .fifo_data(fifo_data), .fifo_re(fifo_re), .rom_addr(rom_addr),
    .rom_data(rom_data), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_data(lb_data), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: registered data out, empty flag from pointers
  logic [19:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_e = (rd_ptr == wr_ptr);
  always @(posedge Clk) begin
    if (fifo_re && !fifo_e) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // ROM model: mode 0 = column ramp for one id/row, 1 = all opaque, 2 = all transparent
  int         rom_mode = 2;
  logic [5:0] exp_id   = '0;
  logic [3:0] exp_row  = '0;

  function automatic logic [7:0] pix(input logic [5:0] id, input logic [3:0] row,
                                     input logic [3:0] col);
    logic [7:0] p;
    p = 8'h00;
    if (rom_mode == 0) p = (id == exp_id && row == exp_row) ? {4'h0, col} : 8'hEE;
    else if (rom_mode == 1) p = {1'b1, id[2:0] ^ row[2:0], col};
    return p;
  endfunction

  always @(posedge Clk) rom_data <= pix(rom_addr[13:8], rom_addr[7:4], rom_addr[3:0]);

  // Scoreboard queue of expected {addr, data} writes, and event logs
  logic [17:0] exp_q [$];
  int re_cycs [$];
  int re_total = 0, we_total = 0, done_total = 0, busy_total = 0;
  int last_done_cyc = 0;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (lb_we) begin
        we_total++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(lb_addr), -1);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", int'(lb_addr), int'(e[17:8]));
          chk("wr_data", int'(lb_data), int'(e[7:0]));
        end
      end
      if (fifo_re) begin
        re_total++;
        re_cycs.push_back(cyc);
        chk("re_while_empty", int'(fifo_e), 0);
      end
      if (done) begin
        done_total++;
        last_done_cyc = cyc;
      end
      if (busy) busy_total++;
    end
  end

  task automatic push_entry(input int x, input int row, input int id);
    logic [9:0] xv;
    logic [3:0] rv;
    logic [5:0] iv;
    xv = 10'(x);
    rv = 4'(row);
    iv = 6'(id);
    mem[wr_ptr[5:0]] = {xv, rv, iv};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_entry(input int x, input int row, input int id);
    for (int c = 0; c < 16; c++) begin
      logic [7:0] p;
      p = pix(6'(id), 4'(row), 4'(c));
      if (p != 8'h00 && (x + c) < 640) exp_q.push_back({10'(x + c), p});
    end
  endtask

  int start_cyc = 0;
  task automatic pulse_start();
    @(posedge Clk);
    #1 start = 1'b1;
    start_cyc = cyc;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_total;
    n = 0;
    while (done_total == d0 && n < budget) begin
      @(posedge Clk);
      n++;
    end
    if (done_total == d0) chk({name, "_done_timeout"}, 0, 1);
    @(posedge Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge Clk);
    chk({tag, "_fifo_re"}, int'(fifo_re), 0);
    chk({tag, "_lb_we"}, int'(lb_we), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_lb_addr"}, int'(lb_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, d0, b0, n0;

    check_reset_outputs("por");
    @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk);

    // T1: reset in the middle of DRAW
    rom_mode = 2;
    push_entry(200, 1, 1);
    push_entry(300, 1, 1);
    pulse_start();
    repeat (8) @(posedge Clk);
    #1 Reset = 1'b1;
    check_reset_outputs("t1_reset");
    @(posedge Clk);
    #1 Reset = 1'b0;
    r0 = re_total;
    repeat (30) @(posedge Clk);
    chk("t1_no_re_after_reset", re_total - r0, 0);
    chk("t1_fifo_left", wr_ptr - rd_ptr, 1);
    d0 = done_total;
    pulse_start();
    wait_done("t1_drain", 60);
    chk("t1_drain_re", re_total - r0, 1);
    chk("t1_drain_done", done_total - d0, 1);

    // T2: single entry, column ramp
    rom_mode = 0;
    exp_id = 6'd5;
    exp_row = 4'd3;
    w0 = we_total;
    r0 = re_total;
    push_entry(100, 3, 5);
    expect_entry(100, 3, 5);
    pulse_start();
    wait_done("t2", 60);
    chk("t2_writes", we_total - w0, 15);
    chk("t2_re_count", re_total - r0, 1);
    chk("t2_done_latency", last_done_cyc - re_cycs[$], 19);
    chk("t2_sb_empty", exp_q.size(), 0);

    // T3: right-edge clipping
    rom_mode = 1;
    w0 = we_total;
    push_entry(630, 1, 2);
    expect_entry(630, 1, 2);
    pulse_start();
    wait_done("t3", 60);
    chk("t3_writes", we_total - w0, 10);
    chk("t3_sb_empty", exp_q.size(), 0);

    // T4: three entries back to back
    w0 = we_total;
    d0 = done_total;
    n0 = re_cycs.size();
    push_entry(10, 0, 1);
    push_entry(300, 7, 2);
    push_entry(620, 15, 63);
    expect_entry(10, 0, 1);
    expect_entry(300, 7, 2);
    expect_entry(620, 15, 63);
    pulse_start();
    wait_done("t4", 120);
    chk("t4_re_count", re_cycs.size() - n0, 3);
    if (re_cycs.size() - n0 == 3) begin
      chk("t4_re_gap1", re_cycs[n0+1] - re_cycs[n0], 18);
      chk("t4_re_gap2", re_cycs[n0+2] - re_cycs[n0], 36);
      chk("t4_done_latency", last_done_cyc - re_cycs[n0], 55);
    end
    chk("t4_writes", we_total - w0, 48);
    chk("t4_done_count", done_total - d0, 1);
    chk("t4_sb_empty", exp_q.size(), 0);

    // T5: start with empty FIFO
    r0 = re_total;
    w0 = we_total;
    b0 = busy_total;
    pulse_start();
    wait_done("t5", 10);
    repeat (3) @(posedge Clk);
    chk("t5_done_latency", last_done_cyc - start_cyc, 2);
    chk("t5_no_re", re_total - r0, 0);
    chk("t5_no_we", we_total - w0, 0);
    chk("t5_busy_cycles", busy_total - b0, 2);

    // T6: second start during DRAW is ignored
    r0 = re_total;
    w0 = we_total;
    d0 = done_total;
    push_entry(50, 2, 9);
    expect_entry(50, 2, 9);
    pulse_start();
    repeat (6) @(posedge Clk);
    pulse_start();
    wait_done("t6", 60);
    repeat (10) @(posedge Clk);
    chk("t6_done_count", done_total - d0, 1);
    chk("t6_re_count", re_total - r0, 1);
    chk("t6_writes", we_total - w0, 16);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
